i2c_target_regfile: RTL
=======================

# i2c_target_regfile

I2C target (slave) responder with an internal byte-wide register file: the far end of the bus driven by the bridge's I2C master. It decodes START/STOP, matches a 7-bit device address, and accepts register writes (dev-addr, reg-addr, data…). It answers reads (dev-addr+R after a register-address write) with auto-incrementing register contents. It is used as the on-chip bus model and loopback target for bridge verification, and as a synthesizable peripheral.

## Interface
- `DEV_ADDR`, 7'h50, 7-bit target address matched against the first byte's bits [7:1].
- `NUM_REGS`, 16, register-file depth; must be a power of two, 2..256. Pointer width is `PW = $clog2(NUM_REGS)`.
- `clk` input 1: single system clock; must be ≥ 8× SCL frequency.
- `resetn` input 1: asynchronous, active-low reset.
- `scl_i` input 1: raw SCL from the pad, asynchronous.
- `sda_i` input 1: raw SDA from the pad, asynchronous.
- `sda_oe_o` output 1: 1 = pull SDA low (open-drain). SDA is never driven high.
- `wr_strobe_o` output 1: one-cycle pulse per data byte committed to the register file.
- `wr_addr_o` output 8: register index of that write, zero-extended.
- `wr_data_o` output 8: byte written.
- `busy_o` output 1: high from an addressed START (address match) until STOP.

## Operation
- Input conditioning: 2-flop synchronizer per line, then a third flop for edge detect. All internal decisions use the synchronized values.
- START: sync SDA falls while sync SCL is high. STOP: sync SDA rises while sync SCL is high.
- Bits are sampled on the sync SCL rising edge, MSB first. `sda_oe_o` changes only on the sync SCL falling edge, or on STOP/reset.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
- IDLE → ADDR on START; bit counter cleared.
- ADDR: shift 8 bits. On the falling edge after bit 8:
  - match: assert ACK, go to ADDR_ACK, set `busy_o`.
  - mismatch: go to IDLE, no ACK, bus ignored until the next START.
- ADDR_ACK: release on the next falling edge.
  - R/W=0 → REG.
  - R/W=1 → load `regs[ptr]` into the shifter, drive bit 7, go to RDATA.
- REG: 8 bits → `ptr <= byte[PW-1:0]`; upper bits are ignored. ACK → REG_ACK → WDATA.
- WDATA: 8 bits → on the falling edge after bit 8:
  - `regs[ptr] <= byte`, pulse `wr_strobe_o` with `wr_addr_o = ptr` (pre-increment).
  - ACK, `ptr <= ptr+1` (wraps NUM_REGS-1 → 0), go to WDATA_ACK → WDATA.
- RDATA: the target drives `sda_oe_o = ~shift[7]` on each falling edge. After 8 bits it releases SDA and goes to RDATA_ACK; the master's bit is sampled on the rising edge.
  - master ACK (0): `ptr++` (wrap), load the next byte, → RDATA.
  - master NACK (1): `ptr++`, go to IDLE (SDA released, waits for STOP/START).
- Repeated START in any state → ADDR. `ptr` is preserved, giving combined write-pointer/read transfers.
- STOP in any state → IDLE: `sda_oe_o=0`, `busy_o=0`; a partial byte is discarded with no write.
- No clock stretching; no general-call support.

## Timing
- Reset values: `sda_oe_o=0`, `wr_strobe_o=0`, `wr_addr_o=0`, `wr_data_o=0`, `busy_o=0`, all `regs=0`, `ptr=0`, state IDLE.
- Pin-to-detect latency is 3 `clk` cycles. `sda_oe_o` updates on the cycle after the detected SCL fall.
- `wr_strobe_o` is asserted in the same cycle ACK is asserted, for exactly 1 cycle.
- Reset mid-transfer releases SDA immediately (async). After reset the block ignores bus activity until the next START.
- START/STOP detection takes priority over bit sampling when coincident.

## Test plan
- Write: START, 0xA0, 0x03, 0x5A, 0xC3, STOP → three ACKs.
  - `wr_strobe_o` pulses with (3,0x5A) then (4,0xC3); `regs[3]=0x5A`, `regs[4]=0xC3`.
- Combined read: START 0xA0 0x03, Sr 0xA1, read 2 bytes (ACK, NACK), STOP → SDA returns 0x5A then 0xC3; `ptr=5`.
- Address mismatch: START 0xA2 0x00 0xFF STOP → `sda_oe_o` stays 0 throughout, no strobe, `busy_o` stays 0.
- Wrap: write 0x0F, then data 0x11, 0x22 → `regs[15]=0x11`, `regs[0]=0x22`. Reg-addr 0x13 → `ptr=3`.
- STOP after 5 data bits → no strobe, IDLE, `sda_oe_o=0`. Next full write transfer succeeds.
- Assert `resetn=0` while the target drives a 0 data bit → `sda_oe_o` drops the same cycle; all registers read back 0x00.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register file: write pointer, burst writes,
// auto-incrementing reads and combined (repeated-START) transfers.
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NUM_REGS = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic       wr_strobe_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o
);

  localparam int PW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [7:0]    shift, shift_nx;
  logic [PW-1:0] ptr, ptr_nx, ptr_inc;
  logic [7:0]    ptr_ext;
  logic          rw, rw_nx;
  logic          mack, mack_nx;
  logic          oe, oe_nx;
  logic          busy, busy_nx;
  logic          strobe, strobe_nx;
  logic [7:0]    waddr, waddr_nx;
  logic [7:0]    wdata, wdata_nx;
  logic          we;
  logic [7:0]    regs [NUM_REGS];

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;
  logic scl_rise, scl_fall, start_det, stop_det;

  // Synchronizer stages p0/p1, p2 holds the previous synchronized value
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= scl_i;
      scl_p1 <= scl_p0;
      scl_p2 <= scl_p1;
      sda_p0 <= sda_i;
      sda_p1 <= sda_p0;
      sda_p2 <= sda_p1;
    end
  end

  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;
  assign ptr_inc   = ptr + 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      shift  <= 8'd0;
      ptr    <= '0;
      rw     <= 1'b0;
      mack   <= 1'b1;
      oe     <= 1'b0;
      busy   <= 1'b0;
      strobe <= 1'b0;
      waddr  <= 8'd0;
      wdata  <= 8'd0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      shift  <= shift_nx;
      ptr    <= ptr_nx;
      rw     <= rw_nx;
      mack   <= mack_nx;
      oe     <= oe_nx;
      busy   <= busy_nx;
      strobe <= strobe_nx;
      waddr  <= waddr_nx;
      wdata  <= wdata_nx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'd0;
    end else if (we) begin
      regs[ptr] <= shift;
    end
  end

  // STOP/START win over bit sampling; SDA drive changes only on SCL falls
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    shift_nx  = shift;
    ptr_nx    = ptr;
    rw_nx     = rw;
    mack_nx   = mack;
    oe_nx     = oe;
    busy_nx   = busy;
    strobe_nx = 1'b0;
    waddr_nx  = waddr;
    wdata_nx  = wdata;
    we        = 1'b0;
    ptr_ext   = 8'd0;
    ptr_ext[PW-1:0] = ptr;

    if (stop_det) begin
      state_nx = IDLE;
      cnt_nx   = 4'd0;
      oe_nx    = 1'b0;
      busy_nx  = 1'b0;
    end else if (start_det) begin
      state_nx = ADDR;
      cnt_nx   = 4'd0;
    end else if (scl_rise) begin
      case (state)
        ADDR, REG, WDATA: begin
          shift_nx = {shift[6:0], sda_p1};
          cnt_nx   = cnt + 4'd1;
        end
        RDATA:     cnt_nx  = cnt + 4'd1;
        RDATA_ACK: mack_nx = sda_p1;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ADDR: begin
          if (cnt == 4'd8) begin
            if (shift[7:1] == DEV_ADDR) begin
              oe_nx    = 1'b1;
              busy_nx  = 1'b1;
              rw_nx    = shift[0];
              state_nx = ADDR_ACK;
            end else begin
              busy_nx  = 1'b0;
              state_nx = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          cnt_nx = 4'd0;
          if (rw) begin
            shift_nx = regs[ptr];
            oe_nx    = ~regs[ptr][7];
            state_nx = RDATA;
          end else begin
            oe_nx    = 1'b0;
            state_nx = REG;
          end
        end
        REG: begin
          if (cnt == 4'd8) begin
            ptr_nx   = shift[PW-1:0];
            oe_nx    = 1'b1;
            state_nx = REG_ACK;
          end
        end
        REG_ACK, WDATA_ACK: begin
          oe_nx    = 1'b0;
          cnt_nx   = 4'd0;
          state_nx = WDATA;
        end
        WDATA: begin
          if (cnt == 4'd8) begin
            we        = 1'b1;
            strobe_nx = 1'b1;
            waddr_nx  = ptr_ext;
            wdata_nx  = shift;
            oe_nx     = 1'b1;
            ptr_nx    = ptr_inc;
            state_nx  = WDATA_ACK;
          end
        end
        RDATA: begin
          if (cnt == 4'd8) begin
            oe_nx    = 1'b0;
            cnt_nx   = 4'd0;
            state_nx = RDATA_ACK;
          end else begin
            shift_nx = {shift[6:0], 1'b0};
            oe_nx    = ~shift[6];
          end
        end
        RDATA_ACK: begin
          ptr_nx = ptr_inc;
          cnt_nx = 4'd0;
          if (!mack) begin
            shift_nx = regs[ptr_inc];
            oe_nx    = ~regs[ptr_inc][7];
            state_nx = RDATA;
          end else begin
            oe_nx    = 1'b0;
            state_nx = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe_o    = oe;
  assign wr_strobe_o = strobe;
  assign wr_addr_o   = waddr;
  assign wr_data_o   = wdata;
  assign busy_o      = busy;

endmodule
